// File: rtl/sram_controller.sv
// Sequences one 32-bit MEM-stage word access into two 16-bit SRAM half-accesses,
// low half first, stretching each half to ACCESS_CYCLES clocks.
module sram_controller #(
  parameter int ACCESS_CYCLES = 4,
  parameter int BASE_ADDR     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N
);

  // state | meaning
  // IDLE  | waiting for wr_en/rd_en
  // LOW   | half-access to SRAM word {offs[18:2],0}
  // HIGH  | half-access to SRAM word {offs[18:2],1}
  // DONE  | word complete, ready high for one cycle
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0]  LAST    = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0]  PENULT  = 4'(ACCESS_CYCLES - 2);
  localparam logic [18:0] BASE_LO = 19'(BASE_ADDR);

  state_t      state;
  logic [3:0]  cnt;
  logic        op_write;
  logic        dq_oe;
  logic [18:0] offs;
  logic        half;
  logic        unused_bits;

  // Only offs[18:2] reaches the SRAM, so the low 19 bits of the subtraction suffice.
  assign offs        = address[18:0] - BASE_LO;
  assign half        = (state == HIGH);
  assign SRAM_ADDR   = {offs[18:2], half};
  assign unused_bits = ^{address[31:19], offs[1:0]};

  assign SRAM_DQ = dq_oe ? (half ? write_data[31:16] : write_data[15:0]) : 16'hzzzz;
  assign ready   = (state == DONE) || ((state == IDLE) && !wr_en && !rd_en);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op_write  <= 1'b0;
      dq_oe     <= 1'b0;
      SRAM_WE_N <= 1'b1;
      read_data <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en || rd_en) begin
            state     <= LOW;
            cnt       <= 4'd0;
            op_write  <= wr_en;
            dq_oe     <= wr_en;
            SRAM_WE_N <= !wr_en;
          end
        end
        LOW, HIGH: begin
          if (cnt == LAST) begin
            cnt <= 4'd0;
            if (!op_write) begin
              if (state == LOW) read_data[15:0]  <= SRAM_DQ;
              else              read_data[31:16] <= SRAM_DQ;
            end
            if (state == LOW) begin
              state     <= HIGH;
              SRAM_WE_N <= !op_write;
            end else begin
              state     <= DONE;
              dq_oe     <= 1'b0;
              SRAM_WE_N <= 1'b1;
            end
          end else begin
            cnt <= cnt + 4'd1;
            // WE_N releases one cycle before the phase ends so the address is stable at its rise.
            SRAM_WE_N <= !(op_write && (cnt < PENULT));
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small behavioural 16-bit SRAM on the bus.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  tri1  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] mem [0:63];

  int          obs_low;
  int          obs_we0;
  int          obs_we1;
  int          obs_nseq;
  logic [17:0] obs_a0;
  logic [17:0] obs_a1;

  sram_controller #(.ACCESS_CYCLES(4), .BASE_ADDR(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (sram_dq),
    .SRAM_ADDR  (sram_addr),
    .SRAM_WE_N  (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: drives the bus only while a pure read is requested; latches on WE_N rise.
  assign sram_dq = (rd_en && !wr_en) ? mem[sram_addr[5:0]] : 16'hzzzz;
  always @(posedge sram_we_n) if (wr_en) mem[sram_addr[5:0]] = sram_dq;

  task automatic run_xfer(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input bit from_done);
    int guard;
    logic [17:0] last;
    wr_en = w; rd_en = r; address = a; write_data = d;
    obs_low = 0; obs_we0 = 0; obs_we1 = 0; obs_nseq = 0;
    obs_a0 = '1; obs_a1 = '1; last = '0; guard = 0;
    if (from_done) @(negedge clk);
    #1;
    while (!ready && guard < 60) begin
      obs_low++; guard++;
      @(negedge clk); #1;
      if (!ready) begin
        if (!sram_we_n) begin
          if (sram_addr[0]) obs_we1++; else obs_we0++;
        end
        if (obs_nseq == 0 || sram_addr != last) begin
          if (obs_nseq == 0) obs_a0 = sram_addr;
          else if (obs_nseq == 1) obs_a1 = sram_addr;
          obs_nseq++;
          last = sram_addr;
        end
      end
    end
  endtask

  task automatic idle_req();
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = 32'd1024; write_data = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", ready); end
    tests_run++; if (sram_we_n !== 1'b1) begin tests_failed++; $display("FAIL reset_we_n got %b want 1", sram_we_n); end
    tests_run++; if (sram_dq !== 16'hFFFF) begin tests_failed++; $display("FAIL reset_dq_released got %h want ffff (pulled)", sram_dq); end
    tests_run++; if (read_data !== 32'h0) begin tests_failed++; $display("FAIL reset_read_data got %h want 0", read_data); end
  endtask

  task automatic test_write();
    run_xfer(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
    tests_run++; if (obs_low !== 9) begin tests_failed++; $display("FAIL write_ready_low got %0d want 9", obs_low); end
    tests_run++; if (obs_we0 !== 3 || obs_we1 !== 3) begin tests_failed++; $display("FAIL write_we_low got %0d/%0d want 3/3", obs_we0, obs_we1); end
    tests_run++; if (obs_nseq !== 2 || obs_a0 !== 18'd0 || obs_a1 !== 18'd1) begin tests_failed++; $display("FAIL write_addr_seq got n=%0d %0d,%0d want n=2 0,1", obs_nseq, obs_a0, obs_a1); end
    tests_run++; if (read_data !== 32'h0) begin tests_failed++; $display("FAIL write_read_data_held got %h want 0", read_data); end
    idle_req();
    tests_run++; if (mem[0] !== 16'hBEEF || mem[1] !== 16'hDEAD) begin tests_failed++; $display("FAIL write_words01 got %h/%h want beef/dead", mem[0], mem[1]); end
  endtask

  task automatic test_read();
    run_xfer(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
    tests_run++; if (obs_low !== 9) begin tests_failed++; $display("FAIL read_ready_low got %0d want 9", obs_low); end
    tests_run++; if (read_data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL read_data got %h want deadbeef", read_data); end
    tests_run++; if (obs_nseq !== 2 || obs_a0 !== 18'd0 || obs_a1 !== 18'd1) begin tests_failed++; $display("FAIL read_addr_seq got n=%0d %0d,%0d want n=2 0,1", obs_nseq, obs_a0, obs_a1); end
    tests_run++; if (obs_we0 + obs_we1 !== 0) begin tests_failed++; $display("FAIL read_we_n got %0d low cycles want 0", obs_we0 + obs_we1); end
    idle_req();
  endtask

  task automatic test_back_to_back();
    run_xfer(1'b1, 1'b0, 32'd1028, 32'h12345678, 1'b0);
    tests_run++; if (obs_low !== 9) begin tests_failed++; $display("FAIL b2b_write_ready_low got %0d want 9", obs_low); end
    tests_run++; if (obs_nseq !== 2 || obs_a0 !== 18'd2 || obs_a1 !== 18'd3) begin tests_failed++; $display("FAIL b2b_write_addr_seq got n=%0d %0d,%0d want n=2 2,3", obs_nseq, obs_a0, obs_a1); end
    run_xfer(1'b0, 1'b1, 32'd1028, 32'h0, 1'b1);
    tests_run++; if (obs_low !== 9) begin tests_failed++; $display("FAIL b2b_read_ready_low got %0d want 9", obs_low); end
    tests_run++; if (obs_nseq !== 2 || obs_a0 !== 18'd2 || obs_a1 !== 18'd3) begin tests_failed++; $display("FAIL b2b_read_addr_seq got n=%0d %0d,%0d want n=2 2,3", obs_nseq, obs_a0, obs_a1); end
    tests_run++; if (read_data !== 32'h12345678) begin tests_failed++; $display("FAIL b2b_read_data got %h want 12345678", read_data); end
    tests_run++; if (mem[2] !== 16'h5678 || mem[3] !== 16'h1234) begin tests_failed++; $display("FAIL b2b_words23 got %h/%h want 5678/1234", mem[2], mem[3]); end
    idle_req();
  endtask

  task automatic test_simultaneous();
    run_xfer(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 1'b0);
    tests_run++; if (obs_low !== 9) begin tests_failed++; $display("FAIL both_ready_low got %0d want 9", obs_low); end
    tests_run++; if (obs_we0 !== 3 || obs_we1 !== 3) begin tests_failed++; $display("FAIL both_we_low got %0d/%0d want 3/3", obs_we0, obs_we1); end
    tests_run++; if (read_data !== 32'h12345678) begin tests_failed++; $display("FAIL both_read_data_held got %h want 12345678", read_data); end
    idle_req();
    tests_run++; if (mem[4] !== 16'hF00D || mem[5] !== 16'hCAFE) begin tests_failed++; $display("FAIL both_words45 got %h/%h want f00d/cafe", mem[4], mem[5]); end
  endtask

  task automatic test_abort();
    rd_en = 1'b1; wr_en = 1'b0; address = 32'd1024;
    repeat (6) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    tests_run++; if (read_data !== 32'h0) begin tests_failed++; $display("FAIL abort_read_data got %h want 0", read_data); end
    tests_run++; if (sram_we_n !== 1'b1) begin tests_failed++; $display("FAIL abort_we_n got %b want 1", sram_we_n); end
    tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL abort_ready_req got %b want 0", ready); end
    rd_en = 1'b0;
    #1;
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL abort_ready_idle got %b want 1", ready); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    run_xfer(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);
    tests_run++; if (obs_low !== 9) begin tests_failed++; $display("FAIL abort_next_ready_low got %0d want 9", obs_low); end
    tests_run++; if (read_data !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL abort_next_read_data got %h want cafef00d", read_data); end
    idle_req();
  endtask

  task automatic test_cancel();
    rd_en = 1'b1; wr_en = 1'b0; address = 32'd1024;
    #1;
    tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL cancel_ready_req got %b want 0", ready); end
    #1;
    rd_en = 1'b0;
    @(negedge clk); #1;
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL cancel_no_xfer got ready %b want 1", ready); end
    tests_run++; if (read_data !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL cancel_read_data got %h want cafef00d", read_data); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_simultaneous();
    test_abort();
    test_cancel();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
